// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus: ALU and LSU result sources in,
// register-file write port and hazard mask out.
interface wb_arbiter_if;
    logic        alu_valid_i;
    logic [4:0]  alu_rd_i;
    logic [31:0] alu_value_i;
    logic        lsu_valid_i;
    logic [4:0]  lsu_rd_i;
    logic [31:0] lsu_value_i;
    logic        lsu_ready_o;
    logic [4:0]  rd0_o;
    logic [31:0] rd0_value_o;
    logic [31:0] pending_mask_o;

    // Arbiter side
    modport slave (
        input  alu_valid_i, alu_rd_i, alu_value_i,
        input  lsu_valid_i, lsu_rd_i, lsu_value_i,
        output lsu_ready_o, rd0_o, rd0_value_o,
        output pending_mask_o
    );

    // Execute-unit / register-file side
    modport master (
        output alu_valid_i, alu_rd_i, alu_value_i,
        output lsu_valid_i, lsu_rd_i, lsu_value_i,
        input  lsu_ready_o, rd0_o, rd0_value_o,
        input  pending_mask_o
    );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: ALU has priority, LSU results queue in an
// in-order FIFO with WAW squash and a pending-write mask.
module wb_arbiter #(
    parameter int DEPTH = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    wb_arbiter_if.slave  bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef logic [PW-1:0] ptr_t;

    logic [4:0]       r_rd   [DEPTH];
    logic [31:0]      r_val  [DEPTH];
    logic [DEPTH-1:0] r_live;
    ptr_t             r_head;
    ptr_t             r_tail;
    logic [CW-1:0]    r_count;
    logic [4:0]       r_rd0;
    logic [31:0]      r_val0;

    logic        w_alu_win;
    logic        w_empty;
    logic        w_ready;
    logic        w_acc_wr;
    logic        w_pop;
    logic        w_bypass;
    logic        w_push;
    logic [4:0]  w_nxt_rd;
    logic [31:0] w_nxt_val;
    logic [31:0] w_mask;

    function automatic ptr_t f_inc(input ptr_t p);
        return (p == ptr_t'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_alu_win = bus.alu_valid_i && (bus.alu_rd_i != 5'd0);
    assign w_empty   = (r_count == '0);
    assign w_ready   = (r_count < CW'(DEPTH));
    assign w_acc_wr  = bus.lsu_valid_i && w_ready
                       && (bus.lsu_rd_i != 5'd0);
    assign w_pop     = !w_alu_win && !w_empty;
    assign w_bypass  = !w_alu_win && w_empty && w_acc_wr;
    assign w_push    = w_acc_wr && !w_bypass;

    // Select the result to register for next cycle's write port
    always_comb begin
        w_nxt_rd  = 5'd0;
        w_nxt_val = 32'd0;
        if (w_alu_win) begin
            w_nxt_rd  = bus.alu_rd_i;
            w_nxt_val = bus.alu_value_i;
        end else if (w_pop) begin
            if (r_live[r_head]) begin
                w_nxt_rd  = r_rd[r_head];
                w_nxt_val = r_val[r_head];
            end
        end else if (w_bypass) begin
            w_nxt_rd  = bus.lsu_rd_i;
            w_nxt_val = bus.lsu_value_i;
        end
    end

    // Destinations of live buffered results for RAW stalls
    always_comb begin
        w_mask = 32'd0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_live[i]) w_mask[r_rd[i]] = 1'b1;
        end
        w_mask[0] = 1'b0;
    end

    // FIFO state, squash marking and registered output stage
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_live  <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_rd0   <= 5'd0;
            r_val0  <= 32'd0;
            for (int i = 0; i < DEPTH; i++) begin
                r_rd[i]  <= 5'd0;
                r_val[i] <= 32'd0;
            end
        end else begin
            r_rd0  <= w_nxt_rd;
            r_val0 <= w_nxt_val;
            // Older results to the ALU's rd are now stale
            for (int i = 0; i < DEPTH; i++) begin
                if (w_alu_win && (r_rd[i] == bus.alu_rd_i))
                    r_live[i] <= 1'b0;
            end
            if (w_pop) begin
                r_live[r_head] <= 1'b0;
                r_head         <= f_inc(r_head);
            end
            // Same-cycle LSU result is younger than the ALU write
            if (w_push) begin
                r_live[r_tail] <= 1'b1;
                r_rd[r_tail]   <= bus.lsu_rd_i;
                r_val[r_tail]  <= bus.lsu_value_i;
                r_tail         <= f_inc(r_tail);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    assign bus.lsu_ready_o    = w_ready;
    assign bus.rd0_o          = r_rd0;
    assign bus.rd0_value_o    = r_val0;
    assign bus.pending_mask_o = w_mask;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter (DEPTH=2).
// Inputs change and outputs are sampled 1ns after each posedge.
module tb_wb_arbiter;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    wb_arbiter_if bus ();

    wb_arbiter #(.DEPTH(2)) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_alu(input logic v, input logic [4:0] rd,
                             input logic [31:0] val);
        bus.alu_valid_i = v;
        bus.alu_rd_i    = rd;
        bus.alu_value_i = val;
    endtask

    task automatic drive_lsu(input logic v, input logic [4:0] rd,
                             input logic [31:0] val);
        bus.lsu_valid_i = v;
        bus.lsu_rd_i    = rd;
        bus.lsu_value_i = val;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive_alu(1'b0, 5'd0, 32'd0);
        drive_lsu(1'b0, 5'd0, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_checks++;
            if (bus.rd0_o !== 5'd0 || bus.rd0_value_o !== 32'd0) begin
                n_fail++;
                $display("FAIL reset_rd0 c%0d: got %0d/%h want 0/0",
                         c, bus.rd0_o, bus.rd0_value_o);
            end
            n_checks++;
            if (bus.lsu_ready_o !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_ready: got %b want 1",
                         bus.lsu_ready_o);
            end
            n_checks++;
            if (bus.pending_mask_o !== 32'd0) begin
                n_fail++;
                $display("FAIL reset_mask: got %h want 0",
                         bus.pending_mask_o);
            end
        end
    endtask

    task automatic test_alu();
        drive_alu(1'b1, 5'd5, 32'h1111_1111);
        tick();
        drive_alu(1'b0, 5'd0, 32'd0);
        n_checks++;
        if (bus.rd0_o !== 5'd5 || bus.rd0_value_o !== 32'h1111_1111) begin
            n_fail++;
            $display("FAIL alu_write: got %0d/%h want 5/11111111",
                     bus.rd0_o, bus.rd0_value_o);
        end
        tick();
        n_checks++;
        if (bus.rd0_o !== 5'd0 || bus.rd0_value_o !== 32'd0) begin
            n_fail++;
            $display("FAIL alu_one_cycle: got %0d/%h want 0/0",
                     bus.rd0_o, bus.rd0_value_o);
        end
    endtask

    task automatic test_bypass();
        drive_lsu(1'b1, 5'd7, 32'hDEAD_BEEF);
        n_checks++;
        if (bus.lsu_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL bypass_ready: got %b want 1", bus.lsu_ready_o);
        end
        tick();
        drive_lsu(1'b0, 5'd0, 32'd0);
        n_checks++;
        if (bus.rd0_o !== 5'd7 || bus.rd0_value_o !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL bypass_write: got %0d/%h want 7/deadbeef",
                     bus.rd0_o, bus.rd0_value_o);
        end
        n_checks++;
        if (bus.pending_mask_o !== 32'd0) begin
            n_fail++;
            $display("FAIL bypass_mask: got %h want 0",
                     bus.pending_mask_o);
        end
        tick();
        n_checks++;
        if (bus.rd0_o !== 5'd0) begin
            n_fail++;
            $display("FAIL bypass_idle: got %0d want 0", bus.rd0_o);
        end
    endtask

    task automatic test_rd_zero();
        drive_alu(1'b1, 5'd0, 32'h5A5A_5A5A);
        drive_lsu(1'b1, 5'd3, 32'h0000_0033);
        tick();
        drive_alu(1'b0, 5'd0, 32'd0);
        drive_lsu(1'b1, 5'd0, 32'h0000_0099);
        n_checks++;
        if (bus.rd0_o !== 5'd3 || bus.rd0_value_o !== 32'h33) begin
            n_fail++;
            $display("FAIL alu_x0_nonblock: got %0d/%h want 3/33",
                     bus.rd0_o, bus.rd0_value_o);
        end
        tick();
        drive_lsu(1'b0, 5'd0, 32'd0);
        n_checks++;
        if (bus.rd0_o !== 5'd0 || bus.pending_mask_o !== 32'd0) begin
            n_fail++;
            $display("FAIL lsu_x0_discard: got rd %0d mask %h want 0/0",
                     bus.rd0_o, bus.pending_mask_o);
        end
        tick();
        n_checks++;
        if (bus.rd0_o !== 5'd0 || bus.lsu_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL lsu_x0_after: got rd %0d rdy %b want 0/1",
                     bus.rd0_o, bus.lsu_ready_o);
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0]  exp_rd  [7];
        logic [31:0] exp_val [7];
        exp_rd  = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd8, 5'd9, 5'd10};
        exp_val = '{32'h101, 32'h102, 32'h103, 32'h104,
                    32'hA, 32'hB, 32'hC};
        for (int c = 0; c < 7; c++) begin
            if (c < 4) drive_alu(1'b1, 5'(c + 1), 32'h101 + c);
            else       drive_alu(1'b0, 5'd0, 32'd0);
            if (c == 0)      drive_lsu(1'b1, 5'd8, 32'hA);
            else if (c == 1) drive_lsu(1'b1, 5'd9, 32'hB);
            else if (c < 6)  drive_lsu(1'b1, 5'd10, 32'hC);
            else             drive_lsu(1'b0, 5'd0, 32'd0);
            if (c >= 2 && c <= 4) begin
                n_checks++;
                if (bus.lsu_ready_o !== 1'b0) begin
                    n_fail++;
                    $display("FAIL full_ready c%0d: got %b want 0",
                             c, bus.lsu_ready_o);
                end
            end
            if (c == 2) begin
                n_checks++;
                if (bus.pending_mask_o !== 32'h0000_0300) begin
                    n_fail++;
                    $display("FAIL full_mask: got %h want 00000300",
                             bus.pending_mask_o);
                end
            end
            tick();
            n_checks++;
            if (bus.rd0_o !== exp_rd[c] ||
                bus.rd0_value_o !== exp_val[c]) begin
                n_fail++;
                $display("FAIL b2b_write c%0d: got %0d/%h want %0d/%h",
                         c, bus.rd0_o, bus.rd0_value_o,
                         exp_rd[c], exp_val[c]);
            end
        end
        n_checks++;
        if (bus.pending_mask_o !== 32'd0) begin
            n_fail++;
            $display("FAIL b2b_mask_drain: got %h want 0",
                     bus.pending_mask_o);
        end
        tick();
        n_checks++;
        if (bus.rd0_o !== 5'd0) begin
            n_fail++;
            $display("FAIL b2b_idle: got %0d want 0", bus.rd0_o);
        end
    endtask

    task automatic test_waw_squash();
        drive_alu(1'b1, 5'd1, 32'h77);
        drive_lsu(1'b1, 5'd6, 32'h1);
        tick();
        drive_alu(1'b1, 5'd6, 32'h2);
        drive_lsu(1'b0, 5'd0, 32'd0);
        n_checks++;
        if (bus.pending_mask_o !== 32'h0000_0040) begin
            n_fail++;
            $display("FAIL waw_mask_set: got %h want 00000040",
                     bus.pending_mask_o);
        end
        tick();
        drive_alu(1'b0, 5'd0, 32'd0);
        n_checks++;
        if (bus.rd0_o !== 5'd6 || bus.rd0_value_o !== 32'h2) begin
            n_fail++;
            $display("FAIL waw_alu: got %0d/%h want 6/2",
                     bus.rd0_o, bus.rd0_value_o);
        end
        n_checks++;
        if (bus.pending_mask_o !== 32'd0) begin
            n_fail++;
            $display("FAIL waw_mask_clr: got %h want 0",
                     bus.pending_mask_o);
        end
        tick();
        n_checks++;
        if (bus.rd0_o !== 5'd0) begin
            n_fail++;
            $display("FAIL waw_dead_pop: got %0d/%h want 0",
                     bus.rd0_o, bus.rd0_value_o);
        end
        tick();
        n_checks++;
        if (bus.rd0_o !== 5'd0 || bus.lsu_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL waw_after: got rd %0d rdy %b want 0/1",
                     bus.rd0_o, bus.lsu_ready_o);
        end
    endtask

    task automatic test_mid_reset();
        drive_alu(1'b1, 5'd1, 32'h1);
        drive_lsu(1'b1, 5'd12, 32'h55);
        tick();
        drive_alu(1'b1, 5'd2, 32'h2);
        drive_lsu(1'b1, 5'd13, 32'h66);
        tick();
        drive_alu(1'b0, 5'd0, 32'd0);
        drive_lsu(1'b0, 5'd0, 32'd0);
        n_checks++;
        if (bus.pending_mask_o !== 32'h0000_3000 ||
            bus.lsu_ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL mrst_pre: got mask %h rdy %b want 00003000/0",
                     bus.pending_mask_o, bus.lsu_ready_o);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_checks++;
        if (bus.pending_mask_o !== 32'd0 || bus.lsu_ready_o !== 1'b1 ||
            bus.rd0_o !== 5'd0) begin
            n_fail++;
            $display("FAIL mrst_state: got mask %h rdy %b rd %0d",
                     bus.pending_mask_o, bus.lsu_ready_o, bus.rd0_o);
        end
        for (int c = 0; c < 4; c++) begin
            tick();
            n_checks++;
            if (bus.rd0_o !== 5'd0) begin
                n_fail++;
                $display("FAIL mrst_drop c%0d: got %0d/%h want 0",
                         c, bus.rd0_o, bus.rd0_value_o);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        test_reset();
        test_alu();
        test_bypass();
        test_rd_zero();
        test_back_to_back();
        test_waw_squash();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Writeback arbiter directly upstream of the register file; drives its single write port (rd0 index/value).
- Merges two result sources: the single-cycle ALU path (never stalls, always has priority) and the multi-cycle LSU/MUL path (valid/ready handshake).
- LSU results that lose arbitration are held in a small in-order FIFO.
- Exports a pending-write mask so the issue stage can stall on RAW hazards against buffered results.

Parameters:
- DEPTH, 2, LSU holding FIFO entries; legal 1..4.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-low
- alu_valid_i  in  1  ALU result valid this cycle
- alu_rd_i  in  5  ALU destination register
- alu_value_i  in  32  ALU result
- lsu_valid_i  in  1  LSU/MUL result valid
- lsu_rd_i  in  5  LSU/MUL destination register
- lsu_value_i  in  32  LSU/MUL result
- lsu_ready_o  out  1  arbiter can accept an LSU result
- rd0_o  out  5  register file write index; 0 = no write
- rd0_value_o  out  32  register file write data
- pending_mask_o  out  32  bit r set = live buffered write to xr pending

Behaviour:
- Reset (rst_i==0 at posedge): FIFO emptied, all entries invalidated, rd0_o=0, rd0_value_o=0.
  - Consequently lsu_ready_o=1 and pending_mask_o=0 after reset.
  - Mid-operation reset drops buffered results silently.
- Output stage is registered: a result selected in cycle n appears on rd0_o/rd0_value_o in cycle n+1 for exactly one cycle. Idle cycle: rd0_o=0, rd0_value_o=0.
- Per-cycle selection priority:
  1. alu_valid_i && alu_rd_i!=0 -> ALU result.
  2. FIFO head valid and live -> head result, pop.
  3. FIFO head valid but dead (squashed) -> pop only; no write (rd0_o=0 next cycle).
  4. FIFO empty and LSU handshake this cycle with lsu_rd_i!=0 -> LSU result bypasses FIFO.
  5. Otherwise idle.
- ALU with rd==0 counts as not valid; it does not block the FIFO.
- LSU handshake: accepted when lsu_valid_i && lsu_ready_o.
  - lsu_ready_o = (count < DEPTH); depends on registered count only, never on the same-cycle pop.
  - Accepted result with lsu_rd_i==0: discarded, nothing enqueued.
  - Accepted result not bypassed (rule 4): enqueued at tail as a live entry.
  - Push and pop in the same cycle are legal; count is unchanged.
- WAW squash: when the ALU wins with rd X, every live FIFO entry with rd X is marked dead in that cycle.
  - An LSU result accepted in the same cycle with rd X is younger: it is enqueued live, not squashed.
- pending_mask_o: combinational OR over live FIFO entries of (1<<rd). Bit 0 is always 0. An entry popped in cycle n still shows in cycle n; cleared in n+1.
- FIFO order is strict; entries never reorder. Pointers wrap modulo DEPTH; the full/empty distinction uses the count, not pointer equality.
- rd0_o is never X after reset; values are not forwarded combinationally to the output.

Test Plan:
- Reset then idle -> rd0_o=0, lsu_ready_o=1, pending_mask_o=0 every cycle.
- Single ALU write x5=0x11111111 in cycle 3 -> rd0_o=5, rd0_value_o=0x11111111 in cycle 4 only; next cycle rd0_o=0.
- LSU x7=0xDEADBEEF with FIFO empty and ALU idle -> bypass; write appears next cycle; pending_mask_o stays 0.
- ALU busy 4 cycles (x1..x4) while LSU offers x8=0xA, x9=0xB, x10=0xC (DEPTH=2):
  - x8 and x9 accepted; lsu_ready_o=0 while x10 is held.
  - pending_mask_o=0x00000300.
  - After the ALU goes idle: writes x8, x9, x10 in order on consecutive cycles.
- WAW squash: LSU x6=0x1 buffered, then ALU x6=0x2 -> only x6=0x2 is written; one dead-pop cycle with rd0_o=0; bit 6 of pending_mask_o clears the cycle after the ALU cycle.
- Reset asserted with 2 entries buffered -> next cycle FIFO empty, pending_mask_o=0, no buffered write ever reaches rd0_o.
